tpu_tile_scheduler: RTL and testbench

Top-level sequencer that runs an arbitrary MxN output (shared depth K) on the 4x4 TPU core as a series of 4x4 output tiles. It computes per-tile A/B/C buffer base addresses, starts the core once per tile, tracks its busy handshake, and reports completion or handshake timeout to the host/CFU wrapper. It sits between the host command interface and the core FSM.

---
 rtl/tpu_tile_scheduler_pkg.sv | 22 ++
 rtl/tpu_tile_addr_gen.sv | 27 ++
 rtl/tpu_tile_scheduler.sv | 173 +++++++++++++++++
 tb/tb_tpu_tile_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_tile_scheduler_pkg.sv
// Shared definitions for the TPU tile scheduler: FSM state encoding,
// default tiling/timeout parameters and the tile-index width.
package tpu_tile_scheduler_pkg;

    // log2 of the core tile edge (4x4 core)
    localparam int TILE_LOG2_DEF   = 2;
    // cycles allowed between core_start and core_busy rising
    localparam int ACK_TIMEOUT_DEF = 16;
    // width of tile counts and tile indices (ceil(255/4) = 64 fits)
    localparam int TILE_W          = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_ADVANCE   = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

endpackage

// File: rtl/tpu_tile_addr_gen.sv
// Per-tile buffer base address generator. Inputs are all registered in the
// scheduler, so the bases are stable for as long as the tile indices are.
module tpu_tile_addr_gen
    import tpu_tile_scheduler_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int DIM_BITS  = 8,
    parameter int TILE_LOG2 = TILE_LOG2_DEF
) (
    input  logic [TILE_W-1:0]    tile_m,
    input  logic [TILE_W-1:0]    tile_n,
    input  logic [TILE_W-1:0]    nt,
    input  logic [DIM_BITS-1:0]  k,
    output logic [ADDR_BITS-1:0] a_base,
    output logic [ADDR_BITS-1:0] b_base,
    output logic [ADDR_BITS-1:0] c_base
);

    // A rows and B columns advance by K words per tile; C advances by one
    // tile-row of output rows per tile in row-major tile order.
    always_comb begin
        a_base = ADDR_BITS'(tile_m) * ADDR_BITS'(k);
        b_base = ADDR_BITS'(tile_n) * ADDR_BITS'(k);
        c_base = (ADDR_BITS'(tile_m) * ADDR_BITS'(nt) + ADDR_BITS'(tile_n)) << TILE_LOG2;
    end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Top-level tile sequencer: splits an MxN (depth K) job into 4x4 output
// tiles, starts the core once per tile, watches its busy handshake and
// reports done or an acknowledge timeout to the host.
module tpu_tile_scheduler
    import tpu_tile_scheduler_pkg::*;
#(
    parameter int ADDR_BITS   = 16,
    parameter int DIM_BITS    = 8,
    parameter int TILE_LOG2   = TILE_LOG2_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DIM_BITS-1:0]  K,
    input  logic [DIM_BITS-1:0]  M,
    input  logic [DIM_BITS-1:0]  N,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 core_start,
    input  logic                 core_busy,
    output logic [DIM_BITS-1:0]  core_K,
    output logic [ADDR_BITS-1:0] A_base,
    output logic [ADDR_BITS-1:0] B_base,
    output logic [ADDR_BITS-1:0] C_base,
    output logic [TILE_W-1:0]    tile_m,
    output logic [TILE_W-1:0]    tile_n
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int EXT_W = DIM_BITS + 1;
    localparam int ROUND = (1 << TILE_LOG2) - 1;

    state_t              state, state_nxt;
    logic [DIM_BITS-1:0] k_q, m_q, n_q;
    logic [TILE_W-1:0]   mt_q, nt_q;
    logic [TILE_W-1:0]   tile_m_q, tile_n_q;
    logic [CNT_W-1:0]    ack_cnt;
    logic                error_q;
    logic                accept, timeout;
    logic                last_col, last_row;
    logic [TILE_W-1:0]   mt_calc, nt_calc;

    // Tile counts: ceil(dim / tile_edge), widened so M+3 cannot wrap.
    assign mt_calc  = TILE_W'((EXT_W'(m_q) + EXT_W'(ROUND)) >> TILE_LOG2);
    assign nt_calc  = TILE_W'((EXT_W'(n_q) + EXT_W'(ROUND)) >> TILE_LOG2);
    assign last_col = (tile_n_q == TILE_W'(nt_q - TILE_W'(1)));
    assign last_row = (tile_m_q == TILE_W'(mt_q - TILE_W'(1)));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and Moore outputs of the sequencer.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        core_start = 1'b0;
        accept     = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                busy = 1'b1;
                if (k_q == '0 || m_q == '0 || n_q == '0) state_nxt = ST_FINISH;
                else                                     state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                busy       = 1'b1;
                core_start = 1'b1;
                state_nxt  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                busy = 1'b1;
                if (core_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                busy = 1'b1;
                if (!core_busy) state_nxt = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                busy = 1'b1;
                if (last_col && last_row) state_nxt = ST_FINISH;
                else                      state_nxt = ST_ISSUE;
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Job datapath: latched dimensions, tile counts, tile walk, ack timer, error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q      <= '0;
            m_q      <= '0;
            n_q      <= '0;
            mt_q     <= '0;
            nt_q     <= '0;
            tile_m_q <= '0;
            tile_n_q <= '0;
            ack_cnt  <= '0;
            error_q  <= 1'b0;
        end else begin
            if (accept) begin
                k_q     <= K;
                m_q     <= M;
                n_q     <= N;
                error_q <= 1'b0;
            end
            if (timeout) error_q <= 1'b1;
            case (state)
                ST_SETUP: begin
                    mt_q     <= mt_calc;
                    nt_q     <= nt_calc;
                    tile_m_q <= '0;
                    tile_n_q <= '0;
                end
                ST_ISSUE: ack_cnt <= '0;
                ST_WAIT_ACK: ack_cnt <= ack_cnt + CNT_W'(1);
                ST_ADVANCE: begin
                    if (!last_col) begin
                        tile_n_q <= tile_n_q + TILE_W'(1);
                    end else if (!last_row) begin
                        tile_n_q <= '0;
                        tile_m_q <= tile_m_q + TILE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    tpu_tile_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .DIM_BITS  (DIM_BITS),
        .TILE_LOG2 (TILE_LOG2)
    ) u_addr_gen (
        .tile_m (tile_m_q),
        .tile_n (tile_n_q),
        .nt     (nt_q),
        .k      (k_q),
        .a_base (A_base),
        .b_base (B_base),
        .c_base (C_base)
    );

    assign error  = error_q;
    assign core_K = k_q;
    assign tile_m = tile_m_q;
    assign tile_n = tile_n_q;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Self-checking bench for tpu_tile_scheduler: directed jobs plus random
// jobs, with a behavioural core model and a tile-list reference model.
module tb_tpu_tile_scheduler;

    localparam int ADDR_BITS   = 16;
    localparam int DIM_BITS    = 8;
    localparam int ACK_TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [DIM_BITS-1:0]  K, M, N;
    logic                 busy, done, error, core_start, core_busy;
    logic [DIM_BITS-1:0]  core_K;
    logic [ADDR_BITS-1:0] A_base, B_base, C_base;
    logic [6:0]           tile_m, tile_n;

    tpu_tile_scheduler #(
        .ADDR_BITS   (ADDR_BITS),
        .DIM_BITS    (DIM_BITS),
        .TILE_LOG2   (2),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .K          (K),
        .M          (M),
        .N          (N),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .core_start (core_start),
        .core_busy  (core_busy),
        .core_K     (core_K),
        .A_base     (A_base),
        .B_base     (B_base),
        .C_base     (C_base),
        .tile_m     (tile_m),
        .tile_n     (tile_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tm;
        int tn;
        int a;
        int b;
        int c;
        int k;
    } tile_t;

    tile_t exp_q[$];
    int    starts_seen    = 0;
    int    dones_seen     = 0;
    int    last_start_cyc = 0;
    bit    core_never     = 1'b0;
    int    core_dmax      = 3;
    int    core_rmin      = 2;
    int    core_rmax      = 8;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: the ordered list of tiles a job must visit, from the
    // ceil-division tiling and the base-address formulas.
    function automatic int build_expected(input int k, input int m, input int n);
        int mt, nt;
        exp_q.delete();
        if (k == 0 || m == 0 || n == 0) return 0;
        mt = (m + 3) / 4;
        nt = (n + 3) / 4;
        for (int r = 0; r < mt; r++)
            for (int c = 0; c < nt; c++)
                exp_q.push_back('{tm: r, tn: c, a: r * k, b: c * k, c: (r * nt + c) * 4, k: k});
        return mt * nt;
    endfunction

    // Scoreboard: every core_start must match the next expected tile.
    initial begin
        forever begin
            @(negedge clk);
            if (done) dones_seen++;
            if (rst_n && core_start) begin
                starts_seen++;
                last_start_cyc = cyc;
                check("start_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    tile_t e;
                    e = exp_q.pop_front();
                    check("tile_m", tile_m, e.tm);
                    check("tile_n", tile_n, e.tn);
                    check("A_base", A_base, e.a);
                    check("B_base", B_base, e.b);
                    check("C_base", C_base, e.c);
                    check("core_K", core_K, e.k);
                end
            end
        end
    end

    // Core model: after a start, raise busy after a random delay and hold it
    // for a random run length; optionally never acknowledge.
    initial begin
        core_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start && !core_never) begin
                int d, r;
                d = $urandom_range(core_dmax, 0);
                r = $urandom_range(core_rmax, core_rmin);
                repeat (d) @(negedge clk);
                core_busy = 1'b1;
                repeat (r) @(negedge clk);
                core_busy = 1'b0;
            end
        end
    end

    task automatic run_job(input int k, input int m, input int n, input bit never, input bit poke);
        int exp_n, bound, d0;
        bit finished;
        exp_n       = build_expected(k, m, n);
        core_never  = never;
        starts_seen = 0;
        d0          = dones_seen;
        @(negedge clk);
        K = 8'(k); M = 8'(m); N = 8'(n);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        K = 8'($urandom); M = 8'($urandom); N = 8'($urandom);
        check("busy_after_accept", busy, 1);
        check("error_cleared", error, 0);
        if (exp_n == 0) begin
            check("zero_done_early", done, 0);
            @(negedge clk);
            check("zero_done_t2", done, 1);
            check("zero_busy_low", busy, 0);
            @(negedge clk);
            check("zero_done_single", done, 0);
            check("zero_no_start", starts_seen, 0);
            check("zero_no_error", error, 0);
        end else begin
            bound    = exp_n * (core_dmax + core_rmax + 4) + ACK_TIMEOUT + 20;
            finished = 1'b0;
            for (int i = 0; i < bound; i++) begin
                @(negedge clk);
                if (done || (error && !busy)) begin
                    finished = 1'b1;
                    break;
                end
                if (poke && i == 2) begin
                    in_valid = 1'b1;
                    K = 8'($urandom); M = 8'($urandom_range(40, 1)); N = 8'($urandom_range(40, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            in_valid = 1'b0;
            check("job_finished", finished, 1);
            if (never) begin
                check("timeout_error", error, 1);
                check("timeout_busy_low", busy, 0);
                check("timeout_no_done", dones_seen - d0, 0);
                check("timeout_latency", cyc - last_start_cyc, ACK_TIMEOUT + 1);
                check("timeout_starts", starts_seen, 1);
            end else begin
                check("done_busy_low", busy, 0);
                check("done_no_error", error, 0);
                check("start_count", starts_seen, exp_n);
                check("tiles_left", exp_q.size(), 0);
                @(negedge clk);
                check("done_single", done, 0);
                check("busy_idle", busy, 0);
            end
        end
        exp_q.delete();
        core_never = 1'b0;
    endtask

    initial begin
        int seen, d0, s0, k, m, n;
        rst_n = 1'b0; in_valid = 1'b0;
        K = '0; M = '0; N = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_core_start", core_start, 0);
        check("rst_A_base", A_base, 0);
        check("rst_C_base", C_base, 0);
        rst_n = 1'b1;

        run_job(4, 4, 4, 0, 0);
        run_job(16, 8, 8, 0, 1);
        run_job(7, 5, 3, 0, 0);
        run_job(4, 0, 4, 0, 0);
        run_job(0, 4, 4, 0, 0);
        run_job(4, 4, 4, 1, 0);
        run_job(4, 4, 4, 0, 0);

        // Reset during the second tile's WAIT_DONE abandons the job.
        core_dmax = 0; core_rmin = 6; core_rmax = 6;
        void'(build_expected(16, 8, 8));
        @(negedge clk);
        K = 8'd16; M = 8'd8; N = 8'd8; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && seen < 2; i++) begin
            @(negedge clk);
            if (core_start) seen++;
        end
        check("rst_test_second_start", seen, 2);
        repeat (2) @(negedge clk);
        check("pre_reset_tile_n", tile_n, 1);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_core_start", core_start, 0);
        check("mid_rst_tile_m", tile_m, 0);
        check("mid_rst_tile_n", tile_n, 0);
        check("mid_rst_A_base", A_base, 0);
        check("mid_rst_B_base", B_base, 0);
        check("mid_rst_C_base", C_base, 0);
        check("mid_rst_core_K", core_K, 0);
        exp_q.delete();
        d0 = dones_seen; s0 = starts_seen;
        repeat (20) @(negedge clk);
        check("post_rst_no_done", dones_seen - d0, 0);
        check("post_rst_no_start", starts_seen - s0, 0);
        check("post_rst_idle", busy, 0);
        core_dmax = 3; core_rmin = 2; core_rmax = 8;

        for (int j = 0; j < 12; j++) begin
            k = ($urandom_range(3, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(20, 0);
            m = $urandom_range(20, 0);
            n = $urandom_range(20, 0);
            run_job(k, m, n, ($urandom_range(7, 0) == 0), 1'($urandom_range(1, 0)));
        end

        // Largest job: exercises the widest base addresses (16065, 16380).
        core_dmax = 0; core_rmin = 2; core_rmax = 2;
        run_job(255, 255, 255, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
